// File: rtl/fetch_mem_responder.sv
// Memory-side end of the fetch address interface: issues PC-controller addresses to an
// in-order instruction-memory bus and hands {pc, instruction} to decode, dropping stale fetches on flush.
module fetch_mem_responder #(
  parameter int unsigned size      = 32,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] inst_addr,
  input  logic            flush,
  input  logic            decode_stall,
  output logic            buble,
  output logic            instruction_valid,
  output logic [31:0]     instruction,
  output logic [size-1:0] instr_pc,
  output logic            mem_req_valid,
  output logic [size-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   fifo_wr;
  logic [PW-1:0]   fifo_rd;
  logic [PW-1:0]   pcq_wr;
  logic [PW-1:0]   pcq_rd;
  logic [PW-1:0]   pcq_slot;
  logic [size-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [size-1:0] pcq        [DEPTH];

  logic            accept;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            pop;
  logic [CW:0]     credit_used;

  assign instruction_valid = (fifo_count != '0);
  assign instruction       = instruction_valid ? fifo_instr[fifo_rd] : NOP_INSTR;
  assign instr_pc          = instruction_valid ? fifo_pc[fifo_rd] : '0;

  assign pop = instruction_valid & ~decode_stall & ~flush;

  // The head entry leaving this cycle frees its slot, so a 1-cycle memory can stream one per cycle.
  assign credit_used   = {1'b0, inflight} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign mem_req_valid = reset & (credit_used < LIMIT);
  assign mem_req_addr  = inst_addr;
  assign accept        = mem_req_valid & mem_req_ready;
  assign buble         = ~accept;

  assign rsp_drop = mem_rsp_valid & (flush | (drop_cnt != '0));
  assign rsp_keep = mem_rsp_valid & ~rsp_drop;

  // A request accepted during flush is the corrected path: it lands in slot 0 of the cleared queue.
  assign pcq_slot = flush ? '0 : pcq_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight   <= '0;
      drop_cnt   <= '0;
      fifo_count <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      pcq_wr     <= '0;
      pcq_rd     <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(mem_rsp_valid);

      if (flush)
        drop_cnt <= inflight - CW'(mem_rsp_valid);
      else if (rsp_drop)
        drop_cnt <= drop_cnt - CW'(1);

      if (flush) begin
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        pcq_rd     <= '0;
        pcq_wr     <= PW'(accept);
      end else begin
        fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
        if (rsp_keep) fifo_wr <= fifo_wr + PW'(1);
        if (pop)      fifo_rd <= fifo_rd + PW'(1);
        if (accept)   pcq_wr  <= pcq_wr + PW'(1);
        if (rsp_keep) pcq_rd  <= pcq_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pcq[pcq_slot] <= inst_addr;
    if (rsp_keep) begin
      fifo_pc[fifo_wr]    <= pcq[pcq_rd];
      fifo_instr[fifo_wr] <= mem_rsp_data;
    end
  end

  rsp_needs_request: assert property (@(posedge clk) disable iff (!reset)
    mem_rsp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Directed per-cycle vectors for fetch_mem_responder with a bench-side PC controller and
// in-order instruction memory of selectable latency (data = ~address).
module tb_fetch_mem_responder;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] T   = 32'h80000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic        flush;
  logic        decode_stall;
  logic        buble;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  fetch_mem_responder #(
    .size(32),
    .DEPTH(2),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst_addr(inst_addr),
    .flush(flush),
    .decode_stall(decode_stall),
    .buble(buble),
    .instruction_valid(instruction_valid),
    .instruction(instruction),
    .instr_pc(instr_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] tgt;
    logic        st;
    logic        rdy;
    logic        bub;
    logic        mv;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] addr;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } req_t;

  vec_t        vq[$];
  req_t        mq[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned lat      = 1;
  logic [31:0] pc;

  task automatic add(input logic fl, input logic [31:0] tgt, input logic st, input logic rdy,
                     input logic bub, input logic mv, input logic iv,
                     input logic [31:0] ipc, input logic [31:0] addr);
    vec_t v;
    v.fl = fl; v.tgt = tgt; v.st = st; v.rdy = rdy;
    v.bub = bub; v.mv = mv; v.iv = iv; v.ipc = ipc; v.addr = addr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mreq_valid"}, -1, {31'b0, mem_req_valid}, 32'd0);
    chk({tag, "_buble"},      -1, {31'b0, buble},         32'd1);
    chk({tag, "_ivalid"},     -1, {31'b0, instruction_valid}, 32'd0);
    chk({tag, "_instr"},      -1, instruction, NOP);
    chk({tag, "_ipc"},        -1, instr_pc, 32'd0);
  endtask

  // Entered at a negedge; asserts reset immediately and releases it at a later negedge.
  task automatic reset_dut(input string tag, input int unsigned new_lat);
    reset         = 1'b0;
    flush         = 1'b0;
    decode_stall  = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mq.delete();
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    lat       = new_lat;
    cyc       = 0;
    pc        = T;
    inst_addr = T;
    reset     = 1'b1;
  endtask

  task automatic step(input int idx);
    vec_t v;
    logic acc;
    v = vq[idx];
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = ~mq[0].addr;
      mq.delete(0);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    flush = v.fl;
    if (v.fl) pc = v.tgt;
    inst_addr     = pc;
    decode_stall  = v.st;
    mem_req_ready = v.rdy;
    #1;
    chk("buble",      idx, {31'b0, buble},             {31'b0, v.bub});
    chk("mreq_valid", idx, {31'b0, mem_req_valid},     {31'b0, v.mv});
    chk("ivalid",     idx, {31'b0, instruction_valid}, {31'b0, v.iv});
    chk("instr_pc",   idx, instr_pc, v.ipc);
    chk("instr",      idx, instruction, v.iv ? ~v.ipc : NOP);
    chk("mreq_addr",  idx, mem_req_addr, v.addr);
    acc = mem_req_valid & mem_req_ready;
    if (acc) mq.push_back('{cyc + lat, mem_req_addr});
    @(posedge clk);
    if (acc) pc = inst_addr + 32'd4;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(i);
  endtask

  initial begin
    // Run 1 (latency 1): streaming from reset, then decode stall for 5 cycles.
    //  fl tgt st rdy   bub mv iv  ipc       addr
    add(0, 0, 0, 1,   0, 1, 0, 0,        T);
    add(0, 0, 0, 1,   0, 1, 0, 0,        T+4);
    add(0, 0, 0, 1,   0, 1, 1, T,        T+8);
    add(0, 0, 0, 1,   0, 1, 1, T+4,      T+12);
    add(0, 0, 0, 1,   0, 1, 1, T+8,      T+16);
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 1, 1, 0, 1, T+12,     T+20);
    add(0, 0, 0, 1,   0, 1, 1, T+12,     T+20);
    add(0, 0, 0, 1,   0, 1, 1, T+16,     T+24);
    add(0, 0, 0, 1,   0, 1, 1, T+20,     T+28);
    add(0, 0, 0, 1,   0, 1, 1, T+24,     T+32);
    // Run 2 (latency 3): flush over two in-flight fetches, then flush coinciding with response + pop.
    add(0, 0,       0, 1,   0, 1, 0, 0,       T);
    add(0, 0,       0, 1,   0, 1, 0, 0,       T+4);
    add(1, T+'h100, 0, 1,   1, 0, 0, 0,       T+'h100);
    add(0, 0,       0, 1,   1, 0, 0, 0,       T+'h100);
    add(0, 0,       0, 1,   0, 1, 0, 0,       T+'h100);
    add(0, 0,       0, 1,   0, 1, 0, 0,       T+'h104);
    add(0, 0,       0, 1,   1, 0, 0, 0,       T+'h108);
    add(0, 0,       0, 1,   1, 0, 0, 0,       T+'h108);
    add(0, 0,       0, 1,   0, 1, 1, T+'h100, T+'h108);
    add(0, 0,       0, 1,   0, 1, 1, T+'h104, T+'h10C);
    add(0, 0,       0, 1,   1, 0, 0, 0,       T+'h110);
    add(0, 0,       0, 1,   1, 0, 0, 0,       T+'h110);
    add(1, T+'h200, 0, 1,   1, 0, 1, T+'h108, T+'h200);
    add(0, 0,       0, 1,   0, 1, 0, 0,       T+'h200);
    add(0, 0,       0, 1,   0, 1, 0, 0,       T+'h204);
    add(0, 0,       0, 1,   1, 0, 0, 0,       T+'h208);
    add(0, 0,       0, 1,   1, 0, 0, 0,       T+'h208);
    add(0, 0,       0, 1,   0, 1, 1, T+'h200, T+'h208);
    // Run 3 (latency 1): clean restart after mid-flight reset, memory not ready for 3 cycles.
    add(0, 0, 0, 1,   0, 1, 0, 0,        T);
    add(0, 0, 0, 1,   0, 1, 0, 0,        T+4);
    add(0, 0, 0, 0,   1, 1, 1, T,        T+8);
    add(0, 0, 0, 0,   1, 1, 1, T+4,      T+8);
    add(0, 0, 0, 0,   1, 1, 0, 0,        T+8);
    add(0, 0, 0, 1,   0, 1, 0, 0,        T+8);
    add(0, 0, 0, 1,   0, 1, 0, 0,        T+12);
    add(0, 0, 0, 1,   0, 1, 1, T+8,      T+16);
    add(0, 0, 0, 1,   0, 1, 1, T+12,     T+20);

    reset         = 1'b0;
    inst_addr     = T;
    pc            = T;
    flush         = 1'b0;
    decode_stall  = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    @(negedge clk);

    reset_dut("por", 1);
    run(0, 13);
    reset_dut("rst2", 3);
    run(14, 31);
    // Reset lands with a fetch in flight and one instruction buffered.
    reset_dut("midflight", 1);
    run(32, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
